// File: rtl/pc_fetch_unit_pkg.sv
// Shared constants and types for the PC fetch unit: address width, branch-class
// func3 encodings and the fetch FSM state encoding.
package pc_fetch_unit_pkg;

    localparam int ADDR_W = 19;

    typedef logic [ADDR_W-1:0] addr_t;

    typedef enum logic [2:0] {
        F3_BEQ  = 3'd0,
        F3_BNE  = 3'd1,
        F3_BLT  = 3'd2,
        F3_BGE  = 3'd3,
        F3_BLTU = 3'd4,
        F3_BGEU = 3'd5,
        F3_CALL = 3'd6,
        F3_RET  = 3'd7
    } func3_t;

    typedef enum logic [1:0] {
        ST_BOOT     = 2'd0,
        ST_FETCH    = 2'd1,
        ST_WAIT_MEM = 2'd2
    } state_t;

    // Calls and returns always redirect; conditional branches only when taken.
    function automatic logic is_redirect(input logic       is_b,
                                         input logic [2:0] f3,
                                         input logic       taken);
        return is_b && (taken || (f3 == F3_CALL) || (f3 == F3_RET));
    endfunction

endpackage

// File: rtl/pc_fetch_unit_ras.sv
// Circular return-address stack: a push while full overwrites the oldest entry,
// a pop while empty is ignored (the caller decides what to fetch instead).
module return_addr_stack
    import pc_fetch_unit_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_addr,
    output logic [ADDR_W-1:0] top,
    output logic              empty,
    output logic              full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  top_idx;
    logic [PTR_W-1:0]  wr_idx;
    logic [CNT_W-1:0]  count;

    assign wr_idx = top_idx + PTR_W'(1);
    assign empty  = (count == '0);
    assign full   = (count == CNT_MAX);
    assign top    = mem[top_idx];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            top_idx <= '1;
            count   <= '0;
        end else if (push) begin
            top_idx <= wr_idx;
            if (!full) begin
                count <= count + CNT_W'(1);
            end
        end else if (pop && !empty) begin
            top_idx <= top_idx - PTR_W'(1);
            count   <= count - CNT_W'(1);
        end
    end

    // Entry storage needs no reset; the count decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_idx] <= push_addr;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction fetch front end: PC register, fetch handshake FSM, branch/call/ret
// redirects with a one-cycle flush, and a return-address stack for returns.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// BOOT     | one idle cycle after reset, no fetch request
// FETCH    | request at PC; advance on accept, redirect on branch/call/ret
// WAIT_MEM | request held at PC until instruction memory is ready
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter addr_t RESET_PC  = '0,
    parameter int    RAS_DEPTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              is_b_type_i,
    input  logic [2:0]        func3_i,
    input  logic              branch_taken_i,
    input  logic [ADDR_W-1:0] target_i,
    input  logic              stall_i,
    input  logic              imem_ready_i,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic              pc_valid_o,
    output logic              flush_o,
    output logic              ras_ovf_o,
    output logic              ras_unf_o
);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_nxt;
    logic [ADDR_W-1:0] pc_out_nxt;
    logic              valid_nxt;
    logic              flush_nxt;
    logic              unf_nxt;

    logic              active;
    logic              redirect;
    logic              is_call;
    logic              is_ret;
    logic [ADDR_W-1:0] redirect_pc;

    logic              ras_push;
    logic              ras_pop;
    logic [ADDR_W-1:0] ras_top;
    logic              ras_empty;
    logic              ras_full;
    logic [ADDR_W-1:0] ret_addr;

    assign active      = (state != ST_BOOT);
    assign redirect    = active && is_redirect(is_b_type_i, func3_i, branch_taken_i);
    assign is_call     = redirect && (func3_i == F3_CALL);
    assign is_ret      = redirect && (func3_i == F3_RET);
    assign ras_push    = is_call;
    assign ras_pop     = is_ret && !ras_empty;
    assign ret_addr    = pc_o + ADDR_W'(1);

    // An underflowing return has nowhere sensible to go, so restart from reset.
    assign redirect_pc = !is_ret   ? target_i :
                         ras_empty ? RESET_PC : ras_top;

    assign imem_req_o  = active && !stall_i;
    assign imem_addr_o = pc;

    return_addr_stack #(
        .DEPTH(RAS_DEPTH)
    ) u_ras (
        .clk      (clk),
        .reset    (reset),
        .push     (ras_push),
        .pop      (ras_pop),
        .push_addr(ret_addr),
        .top      (ras_top),
        .empty    (ras_empty),
        .full     (ras_full)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc;
        pc_out_nxt = pc_o;
        valid_nxt  = pc_valid_o;
        flush_nxt  = 1'b0;
        unf_nxt    = 1'b0;
        case (state)
            ST_BOOT: begin
                state_nxt = ST_FETCH;
                valid_nxt = 1'b0;
            end
            ST_FETCH, ST_WAIT_MEM: begin
                if (redirect) begin
                    // Redirect beats stall and ready: the in-flight fetch is dropped.
                    state_nxt = ST_FETCH;
                    pc_nxt    = redirect_pc;
                    valid_nxt = 1'b0;
                    flush_nxt = 1'b1;
                    unf_nxt   = is_ret && ras_empty;
                end else if (!stall_i) begin
                    if (imem_ready_i) begin
                        state_nxt  = ST_FETCH;
                        pc_out_nxt = pc;
                        valid_nxt  = 1'b1;
                        pc_nxt     = pc + ADDR_W'(1);
                    end else begin
                        state_nxt = ST_WAIT_MEM;
                        valid_nxt = 1'b0;
                    end
                end
            end
            default: begin
                state_nxt = ST_BOOT;
                valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc         <= RESET_PC;
            pc_o       <= RESET_PC;
            pc_valid_o <= 1'b0;
            flush_o    <= 1'b0;
            ras_unf_o  <= 1'b0;
            ras_ovf_o  <= 1'b0;
        end else begin
            pc         <= pc_nxt;
            pc_o       <= pc_out_nxt;
            pc_valid_o <= valid_nxt;
            flush_o    <= flush_nxt;
            ras_unf_o  <= unf_nxt;
            ras_ovf_o  <= ras_ovf_o | (ras_push & ras_full);
        end
    end

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 19'h00000: first fetch address after reset.
REQ-002 SHALL have parameter RAS_DEPTH, default 8: return-address-stack entries (power of two, 2..16).
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port is_b_type_i, input, 1: the executing instruction is branch/call/ret class.
REQ-006 SHALL have port func3_i, input, 3: 0-5 conditional branch, 6 call, 7 ret.
REQ-007 SHALL have port branch_taken_i, input, 1: outcome from the branch comparator.
REQ-008 SHALL have port target_i, input, 19: branch/call target address.
REQ-009 SHALL have port stall_i, input, 1: downstream pipeline stall; hold PC.
REQ-010 SHALL have port imem_ready_i, input, 1: instruction memory accepts the request this cycle.
REQ-011 SHALL have port imem_req_o, output, 1: fetch request valid.
REQ-012 SHALL have port imem_addr_o, output, 19: fetch address (equals the PC register).
REQ-013 SHALL have port pc_o, output, 19: address of the instruction handed downstream.
REQ-014 SHALL have port pc_valid_o, output, 1: pc_o is valid (fetch accepted, not flushed).
REQ-015 SHALL have port flush_o, output, 1: one-cycle pulse on a redirect; kills the in-flight fetch.
REQ-016 SHALL have port ras_ovf_o, output, 1: sticky flag, a push occurred with the RAS full.
REQ-017 SHALL have port ras_unf_o, output, 1: one-cycle pulse, ret popped an empty RAS.

Function
REQ-018 SHALL implement FSM states BOOT, FETCH and WAIT_MEM; reset enters BOOT.
REQ-019 BOOT SHALL drive imem_req_o=0 for exactly one cycle, then enter FETCH.
REQ-020 In FETCH/WAIT_MEM, imem_req_o SHALL be 1 unless stall_i=1.
REQ-021 FETCH with imem_req_o=1 and imem_ready_i=0 SHALL go to WAIT_MEM and hold the PC; WAIT_MEM SHALL return to FETCH on imem_ready_i=1.
REQ-022 On an accepted request (req&ready) with no redirect, the next cycle SHALL show pc_o=old PC and pc_valid_o=1, with PC=PC+1 mod 2^19 (19'h7FFFF wraps to 0).
REQ-023 Redirect condition: is_b_type_i=1 and (func3 in 0-5 with branch_taken_i=1, or func3=6, or func3=7); func3=6/7 SHALL redirect regardless of branch_taken_i.
REQ-024 Redirect SHALL load PC with target_i (func3 0-6) or the RAS top (func3 7), pulse flush_o, force pc_valid_o=0 next cycle, and enter FETCH; total redirect latency is 1 cycle.
REQ-025 Redirect SHALL take priority over stall_i and over imem_ready_i in the same cycle.
REQ-026 A call SHALL push pc_o+1 (return address); a ret SHALL pop; push and pop are mutually exclusive by encoding.
REQ-027 A push while full SHALL overwrite the oldest entry (circular) and set ras_ovf_o until reset.
REQ-028 A ret with the RAS empty SHALL redirect to RESET_PC, leave the pointer unchanged, and pulse ras_unf_o.
REQ-029 stall_i=1 without a redirect SHALL hold PC, pc_o, pc_valid_o and the FSM state.
REQ-030 Redirect inputs SHALL be sampled only when is_b_type_i=1; other cycles SHALL ignore func3_i and target_i.

Reset
REQ-031 Reset SHALL asynchronously set: PC=RESET_PC, pc_o=RESET_PC, pc_valid_o=0, imem_req_o=0, flush_o=0, ras_ovf_o=0, ras_unf_o=0, RAS empty, state BOOT.
REQ-032 Reset asserted mid-WAIT_MEM or mid-redirect SHALL discard the pending fetch; the first request after release SHALL be RESET_PC.

Structure
REQ-033 Shared package pkgs SHALL hold the 19-bit address width constant, the func3 encodings (including CALL=6, RET=7) and the FSM state enum.
REQ-034 The RAS SHALL be a separate sub-module, return_addr_stack (push, pop, top, empty, full).

Verification
REQ-035 Reset release, imem_ready_i=1 -> req low 1 cycle, then addresses 0,1,2; pc_valid_o high from the 2nd fetch cycle onward.
REQ-036 PC=5, is_b_type=1, func3=0, taken=1, target=19'h100 -> flush_o pulse, next address 19'h100, pc_valid_o=0 for 1 cycle.
REQ-037 Call at pc_o=19'h20, target 19'h200; later ret -> fetch resumes at 19'h21.
REQ-038 9 nested calls with RAS_DEPTH=8 -> ras_ovf_o=1; 8 rets return the newest 8 addresses; a 9th ret -> ras_unf_o pulse, PC=RESET_PC.
REQ-039 imem_ready_i low 3 cycles -> WAIT_MEM, address held; stall_i plus a taken branch in the same cycle -> redirect wins.
REQ-040 PC=19'h7FFFF accepted -> next address 19'h00000; reset pulsed during WAIT_MEM -> next request at RESET_PC.
